// File: rtl/vlg_reset_design.sv
// Reset-style reference cell: one data word registered under async, sync and async-assert/sync-release resets.
// Optional `DATA_SYNC_EN adds a 2-flop input data synchronizer ahead of all three registers.
module vlg_reset_design #(
  parameter int unsigned          DATA_W      = 4,
  parameter int unsigned          SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0]    RST_VAL     = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_asyn_data,
  output logic [DATA_W-1:0] o_sync_data,
  output logic [DATA_W-1:0] o_asyn_data2
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("SYNC_STAGES must be in 2..4");
  end

  logic [DATA_W-1:0] data_src;

`ifdef DATA_SYNC_EN
  logic [DATA_W-1:0] data_meta;
  logic [DATA_W-1:0] data_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_meta <= RST_VAL;
      data_sync <= RST_VAL;
    end else begin
      data_meta <= i_data;
      data_sync <= data_meta;
    end
  end

  assign data_src = data_sync;
`else
  assign data_src = i_data;
`endif

  // Constant 1 ripples in; last stage is the released reset
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rst_sync_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync_n = sync_q[SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_asyn_data <= RST_VAL;
    end else begin
      o_asyn_data <= data_src;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_sync_data <= RST_VAL;
    end else begin
      o_sync_data <= data_src;
    end
  end

  always_ff @(posedge i_clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      o_asyn_data2 <= RST_VAL;
    end else begin
      o_asyn_data2 <= data_src;
    end
  end

endmodule

// File: tb/tb_vlg_reset_design.sv
// Self-checking bench for vlg_reset_design: reference model plus directed reset scenarios.
// Works with or without DATA_SYNC_EN defined.
module tb_vlg_reset_design;

  localparam int DW = 4;
  localparam int SS = 2;
`ifdef DATA_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam int REL = SS + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] data;
  logic [DW-1:0] o_asyn;
  logic [DW-1:0] o_sync;
  logic [DW-1:0] o_asyn2;

  int checks = 0;
  int errors = 0;

  vlg_reset_design #(
    .DATA_W(DW),
    .SYNC_STAGES(SS),
    .RST_VAL('0)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_data(data),
    .o_asyn_data(o_asyn),
    .o_sync_data(o_sync),
    .o_asyn_data2(o_asyn2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: data history of LAT edges, edges counted since release
  logic [DW-1:0] hist [LAT];
  int            rel_cnt = 0;
  logic [DW-1:0] exp_asyn = '0;
  logic [DW-1:0] exp_sync = '0;
  logic [DW-1:0] exp_asyn2 = '0;
  bit            seen_edge = 0;
  bit            cmp_en = 0;

  initial for (int i = 0; i < LAT; i++) hist[i] = '0;

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      if (rel_cnt < 1000) rel_cnt++;
    end else begin
      rel_cnt = 0;
    end
    for (int i = LAT - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = (rst_n === 1'b1) ? data : '0;
    exp_asyn  = (rst_n === 1'b1) ? hist[LAT-1] : '0;
    exp_sync  = (rst_n === 1'b1) ? hist[LAT-1] : '0;
    exp_asyn2 = (rel_cnt >= REL) ? hist[LAT-1] : '0;
    seen_edge = 1;
  end

  always @(negedge rst_n) begin
    rel_cnt   = 0;
    exp_asyn  = '0;
    exp_asyn2 = '0;
    for (int i = 0; i < LAT; i++) hist[i] = '0;
  end

  always @(posedge clk) begin
    #1;
    if (cmp_en && seen_edge) begin
      chk("model_asyn", o_asyn, exp_asyn);
      chk("model_sync", o_sync, exp_sync);
      chk("model_asyn2", o_asyn2, exp_asyn2);
    end
  end

  task automatic release_and_check(input string tag);
    @(posedge clk);
    #5 rst_n = 1'b1;
    for (int n = 1; n <= REL + 1; n++) begin
      @(posedge clk);
      #1;
      chk({tag, "_asyn"}, o_asyn, (n >= LAT) ? 4'hF : 4'h0);
      chk({tag, "_sync"}, o_sync, (n >= LAT) ? 4'hF : 4'h0);
      chk({tag, "_asyn2"}, o_asyn2, (n >= REL) ? 4'hF : 4'h0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] vals [3];
    vals[0] = 4'hF;
    vals[1] = 4'h5;
    vals[2] = 4'hA;
    rst_n = 1'b0;
    data  = 4'hF;
    cmp_en = 1;

    // Initial reset, 100 cycles
    repeat (100) @(posedge clk);
    #1;
    chk("rst_asyn", o_asyn, 4'h0);
    chk("rst_sync", o_sync, 4'h0);
    chk("rst_asyn2", o_asyn2, 4'h0);
    release_and_check("rel1");

    // Steady-state sequence F -> 5 -> A
    for (int i = 0; i < 3 + LAT - 1; i++) begin
      @(negedge clk);
      if (i < 3) data = vals[i];
      @(posedge clk);
      #1;
      if (i - (LAT - 1) >= 0) begin
        chk("seq_asyn", o_asyn, vals[i-(LAT-1)]);
        chk("seq_sync", o_sync, vals[i-(LAT-1)]);
        chk("seq_asyn2", o_asyn2, vals[i-(LAT-1)]);
      end
    end
    @(negedge clk);
    data = 4'hF;
    repeat (10) @(posedge clk);

    // Mid-operation reset asserted 4 after an edge
    #4 rst_n = 1'b0;
    #1;
    chk("mid_asyn_now", o_asyn, 4'h0);
    chk("mid_asyn2_now", o_asyn2, 4'h0);
    chk("mid_sync_hold", o_sync, 4'hF);
    @(posedge clk);
    #1;
    chk("mid_sync_edge", o_sync, 4'h0);
    repeat (9) @(posedge clk);
    release_and_check("rel2");
    repeat (5) @(posedge clk);

    // Short glitch between edges
    #2 rst_n = 1'b0;
    #1;
    chk("gl_asyn", o_asyn, 4'h0);
    chk("gl_asyn2", o_asyn2, 4'h0);
    chk("gl_sync", o_sync, 4'hF);
    #2 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("gl_rec_asyn2", o_asyn2, 4'hF);
    chk("gl_rec_sync", o_sync, 4'hF);

    // Step 0 -> F, appears LAT edges later
    @(negedge clk);
    data = 4'h0;
    repeat (LAT + 1) @(posedge clk);
    @(negedge clk);
    data = 4'hF;
    for (int n = 1; n <= LAT; n++) begin
      @(posedge clk);
      #1;
      chk("step_asyn", o_asyn, (n >= LAT) ? 4'hF : 4'h0);
      chk("step_sync", o_sync, (n >= LAT) ? 4'hF : 4'h0);
      chk("step_asyn2", o_asyn2, (n >= LAT) ? 4'hF : 4'h0);
    end

    // Long constant run
    repeat (2000) @(posedge clk);
    #1;
    chk("long_asyn", o_asyn, 4'hF);
    chk("long_sync", o_sync, 4'hF);
    chk("long_asyn2", o_asyn2, 4'hF);

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
